// File: rtl/j1_arb_pkg.sv
// j1_arb_pkg: shared response-owner/state types and defaults for the j1 memory arbiter
package j1_arb_pkg;
  typedef enum logic [1:0] {RSP_NONE, RSP_CPU, RSP_HOST} rsp_owner_t;
  typedef enum logic {ARB_RUN, ARB_STALL} arb_state_t;
  localparam int STARVE_MAX_DEF = 4;
endpackage

// File: rtl/j1_starve_ctr.sv
// j1_starve_ctr: saturating count of denied host cycles driving a one-cycle RUN/STALL FSM
module j1_starve_ctr
  import j1_arb_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic clk,
  input  logic resetq,
  input  logic host_req,
  input  logic host_gnt,
  output logic stall
);
  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_MAX);
  arb_state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  // count denied host cycles; STALL is entered on the edge where the count reaches the limit
  always_comb begin
    cnt_nxt = (!host_req || host_gnt) ? '0 : (cnt == LIM) ? cnt : cnt + 1'b1;
    state_nxt = (state == ARB_STALL) ? ARB_RUN : (cnt_nxt == LIM) ? ARB_STALL : ARB_RUN;
  end
  // state and counter registers
  always_ff @(posedge clk) begin
    if (!resetq) begin
      state <= ARB_RUN;
      cnt <= '0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
    end
  end
  assign stall = (state == ARB_STALL);
endmodule

// File: rtl/j1_mem_arbiter.sv
// j1_mem_arbiter: shares one sync RAM between the j1 IO port and a host port; J1_ARB_STARVE_GUARD_EN adds host starvation stalls
`ifndef WIDTH
`define WIDTH 16
`endif
module j1_mem_arbiter
  import j1_arb_pkg::*;
#(
  parameter int WIDTH = `WIDTH,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic             clk,
  input  logic             resetq,
  input  logic             cpu_we,
  input  logic             cpu_re,
  input  logic [WIDTH-1:0] cpu_ptr,
  input  logic [WIDTH-1:0] cpu_wdata,
  output logic [WIDTH-1:0] cpu_rdata,
  output logic             cpu_rvalid,
  output logic             cpu_stall,
  input  logic             host_req,
  input  logic             host_we,
  input  logic [WIDTH-1:0] host_addr,
  input  logic [WIDTH-1:0] host_wdata,
  output logic             host_ack,
  output logic [WIDTH-1:0] host_rdata,
  output logic             mem_en,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata
);
  rsp_owner_t rsp_owner;
  logic rsp_we, cpu_gnt, host_gnt, stall;
  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
    $error("j1_mem_arbiter: STARVE_MAX must be in 1..15");
  end
`ifdef J1_ARB_STARVE_GUARD_EN
  j1_starve_ctr #(.STARVE_MAX(STARVE_MAX)) u_starve (
    .clk(clk),
    .resetq(resetq),
    .host_req(host_req),
    .host_gnt(host_gnt),
    .stall(stall)
  );
`else
  assign stall = 1'b0;
`endif
  // grant and RAM mux; the CPU wins unless stalled, the host waits for its previous response to retire
  always_comb begin
    cpu_gnt = resetq && (cpu_re || cpu_we) && !stall;
    host_gnt = resetq && host_req && (rsp_owner != RSP_HOST) && !cpu_gnt;
    mem_en = cpu_gnt || host_gnt;
    mem_we = cpu_gnt ? cpu_we : host_gnt && host_we;
    mem_addr = cpu_gnt ? cpu_ptr : host_gnt ? host_addr : '0;
    mem_wdata = cpu_gnt ? cpu_wdata : host_gnt ? host_wdata : '0;
  end
  // remember who owns the RAM output in the following cycle; a CPU write expects nothing back
  always_ff @(posedge clk) begin
    if (!resetq) begin
      rsp_owner <= RSP_NONE;
      rsp_we <= 1'b0;
    end else begin
      rsp_owner <= (cpu_gnt && !cpu_we) ? RSP_CPU : host_gnt ? RSP_HOST : RSP_NONE;
      rsp_we <= host_we;
    end
  end
  // steer the RAM output; reset suppresses a pending response so the host must re-issue
  always_comb begin
    cpu_rvalid = resetq && (rsp_owner == RSP_CPU);
    host_ack = resetq && (rsp_owner == RSP_HOST);
    cpu_rdata = cpu_rvalid ? mem_rdata : '0;
    host_rdata = (host_ack && !rsp_we) ? mem_rdata : '0;
  end
  assign cpu_stall = stall;
endmodule

// File: doc/j1_mem_arbiter.md
Name: j1_mem_arbiter

Overview:
- Shares one single-port synchronous data RAM between two requesters:
  - the j1 core's IO port (io_we/io_re/io_ptr/io_out/io_in);
  - an external host/loader port with a req/ack handshake.
- The core has absolute priority. The core has no stall input, so host fairness comes from a stall request to the upstream instruction mux, which substitutes an ALU NOP.
- Sits between the j1, the data RAM and the host/debug bridge.

Parameters:
- WIDTH, `WIDTH (16): data and address width of every bus.
- STARVE_MAX, 4: consecutive denied host cycles before cpu_stall is raised (range 1..15).

Ports:
- clk  in  1  rising-edge clock
- resetq  in  1  synchronous, active-low reset
- cpu_we  in  1  core write strobe (j1 io_we)
- cpu_re  in  1  core read strobe (j1 io_re)
- cpu_ptr  in  WIDTH  core address (j1 io_ptr)
- cpu_wdata  in  WIDTH  core write data (j1 io_out)
- cpu_rdata  out  WIDTH  read data to core (j1 io_in)
- cpu_rvalid  out  1  cpu_rdata valid this cycle
- cpu_stall  out  1  upstream must issue ALU NOP this cycle
- host_req  in  1  host request, level
- host_we  in  1  host write (1) / read (0)
- host_addr  in  WIDTH  host address
- host_wdata  in  WIDTH  host write data
- host_ack  out  1  one-cycle completion pulse
- host_rdata  out  WIDTH  host read data, valid with host_ack
- mem_en  out  1  RAM enable
- mem_we  out  1  RAM write enable
- mem_addr  out  WIDTH  RAM address
- mem_wdata  out  WIDTH  RAM write data
- mem_rdata  in  WIDTH  RAM read data, 1-cycle latency

Behaviour:
- Reset (resetq=0 at a clk edge):
  - rsp_owner=NONE, state=RUN, wait counter=0.
  - cpu_rvalid=0, host_ack=0, cpu_stall=0, cpu_rdata=0, host_rdata=0.
  - mem_en=0 whenever no grant.
  - An in-flight host transaction is dropped with no ack; the host must re-issue.
- Grant, combinational each cycle:
  - CPU if (cpu_re|cpu_we) and state=RUN.
  - Else HOST if host_req and rsp_owner!=HOST.
  - Else none.
- mem_* is muxed combinationally from the granted requester. mem_en=1 iff a grant exists. mem_we=granted we.
- cpu_we and cpu_re both high: treated as a write; no rvalid follows.
- Response tracking: rsp_owner is registered at the grant edge as CPU (reads only), HOST (read or write) or NONE.
- Response cycle (the next cycle):
  - rsp_owner=CPU: cpu_rvalid=1 and cpu_rdata=mem_rdata.
  - rsp_owner=HOST: host_ack=1 and host_rdata=mem_rdata (reads) or 0 (writes).
  - Otherwise both data outputs are 0.
- Latency: read data arrives exactly 1 cycle after grant. A CPU write has no response.
- Host handshake:
  - Host fields are sampled only in the grant cycle.
  - host_req may stay high through the ack. A new grant needs rsp_owner!=HOST, so host throughput is at most 1 transaction per 2 cycles.
  - Dropping host_req before grant withdraws the request.
- Starvation FSM (RUN, STALL):
  - The counter increments each cycle host_req=1 with no host grant, saturating at STARVE_MAX.
  - The counter clears on host grant or when host_req=0.
  - RUN -> STALL when the counter = STARVE_MAX.
  - In STALL: cpu_stall=1 (registered, asserted from the STALL entry edge), the CPU is not granted, and the host is granted.
  - STALL -> RUN after exactly one cycle.
  - If host_req drops while in STALL, the stall cycle is spent idle and the FSM returns to RUN.
- Boundaries:
  - Counter saturation prevents wrap.
  - A stall and a pending CPU host-response never conflict, because owners are tracked separately.
  - Reset during STALL returns to RUN with cpu_stall=0.

Optional Feature:
- Macro: J1_ARB_STARVE_GUARD_EN.
- Defined: starvation FSM and counter as above.
- Undefined:
  - Strict CPU priority.
  - cpu_stall tied to 0; counter and FSM not built.
  - The host may starve indefinitely; everything else is unchanged.

Decomposition:
- Package j1_arb_pkg:
  - rsp_owner enum {RSP_NONE, RSP_CPU, RSP_HOST};
  - arbiter state enum {ARB_RUN, ARB_STALL};
  - STARVE_MAX default constant.
- WIDTH comes from common.h.
- One sub-module j1_starve_ctr: saturating wait counter plus RUN/STALL FSM. It is instantiated only under J1_ARB_STARVE_GUARD_EN.

Test Plan:
- CPU read: preload RAM[0x0010]=0xBEEF; cpu_re=1, cpu_ptr=0x0010 for one cycle -> next cycle cpu_rvalid=1, cpu_rdata=0xBEEF; host_ack stays 0.
- Collision: cpu_we=1 (ptr 0x0020, data 0x1234) with host_req=1, host read 0x0020 in the same cycle -> the CPU write is granted first; the host is granted the following cycle; host_ack one cycle later with host_rdata=0x1234.
- Starvation (macro on, STARVE_MAX=4): cpu_re=1 every cycle, host write 0x0030<-0x5A5A held -> cpu_stall=1 for exactly one cycle after 4 denied cycles; the host is granted in that cycle; host_ack follows; RAM[0x0030]=0x5A5A.
- Starvation (macro off): same stimulus for 50 cycles -> cpu_stall never asserted, host_ack never asserted.
- Back-to-back host: host_req held with reads of 0x0001 then 0x0002 -> acks exactly 2 cycles apart, carrying the correct data.
- Reset mid-transaction: host read granted, then resetq=0 in the following cycle -> host_ack=0, cpu_rvalid=0, cpu_stall=0, mem_en=0; after release, a re-issued request completes normally.
